// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the instruction-memory read bus and the fetch-to-decode
//            valid/ready handshake of the fetch unit.
// Signals  : imem_req / imem_addr / imem_rdata - imem read port (1-cycle latency)
//            if_valid / if_ready / if_instr / if_pc - decode handshake
// Modports : master - fetch side (drives imem request, presents instructions)
//            slave  - memory/decode side
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int PC_W    = 9,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [31:0]        if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, if_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Owns the PC, issues word reads to a
//            1-cycle-latency instruction memory, buffers {pc, instr} pairs in
//            a small FIFO and hands them to decode over valid/ready. A branch
//            redirect reloads the PC and flushes all younger fetch state.
// Ports    : clk         - clock, rising edge
//            reset       - asynchronous reset, active low
//            redirect    - branch/jump taken
//            redirect_pc - branch target (bits [PC_W-1:0] used)
//            misalign    - one-cycle pulse for a target with bits [1:0] != 0
//            bus         - imem read bus and decode handshake (master side)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int PC_W    = 9,
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_pc,
  output logic             misalign,
  fetch_unit_if.master     bus
);

  localparam int CW = $clog2(DEPTH + 1);   // count width, holds 0..DEPTH
  localparam int PW = $clog2(DEPTH);       // pointer width
  localparam int EW = PC_W + INSTR_W;      // buffer entry width

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;                 // address of the request now in flight
  logic            inflight;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [EW-1:0]   mem [DEPTH];

  logic            pop;
  logic            push;
  logic            req;
  logic [CW:0]     occupancy;
  logic [EW-1:0]   head;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop  = bus.if_valid & bus.if_ready;
  assign push = inflight & ~redirect;

  // Slots already committed: buffered entries plus the response still on its
  // way, minus the one leaving now. Counting the in-flight response is what
  // keeps the buffer from ever overflowing.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  // Gated by reset so no request escapes while the block is held in reset.
  assign req = reset & ~redirect & (occupancy < (CW+1)'(DEPTH));

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (count != '0);

  assign head         = mem[rd_ptr];
  assign bus.if_instr = head[INSTR_W-1:0];

  generate
    if (PC_W < 32) begin : g_pc_ext
      logic unused_redirect_bits;
      assign bus.if_pc             = {{(32-PC_W){1'b0}}, head[EW-1:INSTR_W]};
      assign unused_redirect_bits  = ^redirect_pc[31:PC_W];
    end else begin : g_pc_full
      assign bus.if_pc = head[EW-1:INSTR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (redirect) begin
      // Flush: the response arriving now is dropped, and any pop this cycle
      // is simply absorbed by clearing the buffer.
      pc       <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      misalign <= |redirect_pc[1:0];
    end else begin
      misalign <= 1'b0;
      inflight <= req;
      if (req) begin
        pc     <= pc + PC_W'(4);
        req_pc <= pc;
      end
      if (push) begin
        mem[wr_ptr] <= {req_pc, bus.imem_rdata};
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A queue-based reference
//            model tracks the PC, the outstanding imem read and the buffered
//            {pc, instr} pairs; every cycle the DUT outputs are compared to it.
//            Directed scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int PC_W    = 9;
  localparam int DEPTH   = 2;
  localparam int INSTR_W = 32;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .misalign    (misalign),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [PC_W-1:0]         m_pc;
  bit                      m_infl;
  logic [PC_W-1:0]         m_infl_pc;
  bit                      m_mis;
  logic [PC_W+INSTR_W-1:0] q[$];

  function automatic logic [INSTR_W-1:0] mem_fn(input logic [PC_W-1:0] a);
    logic [INSTR_W-1:0] v;
    v = INSTR_W'(a);
    return v << 4;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc   = '0;
    m_infl = 1'b0;
    m_mis  = 1'b0;
  endtask

  // One clock cycle: apply inputs after the falling edge, check outputs 1ns
  // later, advance the model at the rising edge, then drive the imem response.
  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit                      e_valid;
    bit                      e_pop;
    bit                      e_req;
    logic [PC_W-1:0]         e_addr;
    logic [PC_W+INSTR_W-1:0] hd;
    redirect     = rd;
    redirect_pc  = rpc;
    bus.if_ready = rdy;
    #1;
    e_valid = (q.size() != 0);
    e_pop   = e_valid && rdy;
    e_req   = !rd && ((q.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
    e_addr  = m_pc;
    chk("if_valid", 64'(bus.if_valid), 64'(e_valid));
    if (e_valid) begin
      hd = q[0];
      chk("if_pc", 64'(bus.if_pc), 64'(hd[PC_W+INSTR_W-1:INSTR_W]));
      chk("if_instr", 64'(bus.if_instr), 64'(hd[INSTR_W-1:0]));
    end
    chk("imem_req", 64'(bus.imem_req), 64'(e_req));
    chk("imem_addr", 64'(bus.imem_addr), 64'(e_addr));
    chk("misalign", 64'(misalign), 64'(m_mis));
    @(posedge clk);
    m_mis = rd && (rpc[1:0] != 2'b00);
    if (rd) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = {rpc[PC_W-1:2], 2'b00};
    end else begin
      if (e_pop) void'(q.pop_front());
      if (m_infl) q.push_back({m_infl_pc, mem_fn(m_infl_pc)});
      m_infl = e_req;
      if (e_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + PC_W'(4);
      end
    end
    #1;
    // Garbage on the data bus whenever no response is due.
    bus.imem_rdata = e_req ? mem_fn(e_addr) : INSTR_W'($urandom);
    @(negedge clk);
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_if_valid"}, 64'(bus.if_valid), 64'(0));
    chk({tag, "_imem_req"}, 64'(bus.imem_req), 64'(0));
    chk({tag, "_if_pc"}, 64'(bus.if_pc), 64'(0));
    chk({tag, "_if_instr"}, 64'(bus.if_instr), 64'(0));
    chk({tag, "_misalign"}, 64'(misalign), 64'(0));
  endtask

  initial begin
    bit          rd;
    logic [31:0] rpc;
    bit          rdy;

    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bus.if_ready   = 1'b0;
    bus.imem_rdata = '0;
    #1 reset = 1'b0;
    #2;
    check_in_reset("rst0");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // 1: streaming with decode always ready
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    // 2: decode stalls, buffer fills, then drains in order
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

    // 3: redirect with one entry buffered and one in flight
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // 4: misaligned target near the top of the address space
    cycle(1'b1, 32'h1FE, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b1);

    // 5: back-to-back redirects, last one wins
    cycle(1'b1, 32'h20, 1'b1);
    cycle(1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // upper redirect_pc bits ignored
    cycle(1'b1, 32'hABCD_E104, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

    // 6: asynchronous reset mid-stream with a full buffer
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
    redirect = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_in_reset("rst_mid");
    @(posedge clk);
    #1;
    check_in_reset("rst_hold");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(0, 9) < 7);
      cycle(rd, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the pipelined core. It owns the PC register and issues word reads to the instruction memory, which has a fixed 1-cycle read latency. Fetched {pc, instr} pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake. It consumes the branch unit's redirect (PcSel/BrPC) and flushes all younger fetch state when a redirect occurs.

Parameters:
PC_W, 9, width of the PC register and of the imem address; addresses wrap modulo 2^PC_W
DEPTH, 2, fetch buffer entries; must be 2 or more
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low; block is held in reset while reset==0
redirect  in  1  PcSel from the branch unit; 1 = branch/jump taken
redirect_pc  in  32  BrPC from the branch unit; only bits [PC_W-1:0] are used
imem_req  out  1  read strobe for imem
imem_addr  out  PC_W  read address; always equals the current PC
imem_rdata  in  INSTR_W  read data, valid exactly one cycle after an imem_req cycle
if_valid  out  1  buffer head holds an instruction
if_ready  in  1  decode accepts the head
if_instr  out  INSTR_W  head instruction
if_pc  out  32  head PC, zero-extended
misalign  out  1  one-cycle pulse when a redirect target has bits [1:0] != 0

Behaviour:
- Reset (reset==0, asynchronous): PC=0, buffer emptied (count=0), inflight=0, misalign=0. Outputs during reset: if_valid=0, imem_req=0, if_instr=0, if_pc=0.
- Definitions: pop = if_valid & if_ready; push = inflight & !redirect.
- imem_req = !redirect & (count + inflight - pop < DEPTH). imem_addr = PC in every cycle.
- The first cycle after reset is released has count=0, so imem_req=1 with addr 0.
- When imem_req=1: PC <= PC + 4 (wraps modulo 2^PC_W), and inflight <= 1. Otherwise inflight <= 0.
- Push writes {PC of the issuing request, imem_rdata} at the tail. The FIFO head is registered, so a pushed entry is visible on if_valid from the next cycle.
- The throughput requirement is 1 instr/cycle sustained when if_ready is held at 1. Pop and push in the same cycle are legal, and count is unchanged.
- if_valid = (count != 0). if_instr and if_pc hold their values while if_valid & !if_ready.
- Redirect (highest priority, applied in the same cycle it is seen):
  - PC <= {redirect_pc[PC_W-1:2], 2'b00}.
  - Buffer cleared (count <= 0); any response arriving this cycle is dropped.
  - imem_req = 0 and inflight <= 0.
  - A pop in this cycle is treated as completed; decode flushing is handled elsewhere.
  - misalign <= (redirect_pc[1:0] != 0) for one cycle. Otherwise misalign <= 0.
- Redirect latency: redirect in cycle t gives imem_req with the target address in t+1, and if_valid with the target instruction in t+3.
- Back-to-back redirects: the last one wins, and each one restarts the latency.
- Full buffer: count==DEPTH & !pop gives no request. The buffer never overflows, because in-flight requests are counted.
- Reset mid-operation discards everything immediately, with no partial push.
- Bits redirect_pc[31:PC_W] are ignored. No error is flagged for them.

Test Plan:
1. Release reset with if_ready=1 and imem returning addr*16 → imem_addr 0,4,8,... on consecutive cycles; if_pc/if_instr pairs (0,0),(4,64),(8,128) on consecutive cycles starting 2 cycles after the first request; no bubbles.
2. Hold if_ready=0 → exactly DEPTH=2 entries fill; imem_req falls to 0; head stays at pc 0. Raise if_ready → order 0,4,8,... is preserved, with no loss or duplication.
3. Stream, then redirect=1 with redirect_pc=0x40 in one cycle while an entry is in flight and one is buffered → imem_req=0 in that cycle; next cycle addr 0x40; if_valid low for 2 cycles, then if_pc=0x40, 0x44; no stale pc is ever delivered.
4. redirect_pc=0x1FE → misalign pulses for exactly 1 cycle; fetch resumes at 0x1FC, followed by 0x000 (PC_W=9 wrap).
5. Redirect on two consecutive cycles (targets 0x20 then 0x80) → first delivered pc is 0x80; 0x20 never appears.
6. Assert reset low mid-stream with a full buffer → if_valid and imem_req are 0 asynchronously. After release, fetch restarts at pc 0.
